// File: rtl/coal_arith_pkg.sv
// rtl/coal_arith_pkg.sv - shared state encodings and widths for the lab arithmetic unit
package coal_arith_pkg;

  localparam int ARITH_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Shared by the multiplier and divider so one controller can drive both
  typedef enum logic [1:0] {
    ARITH_IDLE = ST_IDLE,
    ARITH_BUSY = ST_BUSY,
    ARITH_DONE = ST_DONE
  } arith_state_t;

endpackage

// File: rtl/seq_multiplier_8bit.sv
// rtl/seq_multiplier_8bit.sv - shift-add multiplier, one partial product per clock
// Optional two's-complement operands when SEQ_MUL_SIGNED_EN is defined.
module seq_multiplier_8bit
  import coal_arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ready
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  arith_state_t      state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     product_q, product_d;
  logic              ready_q, ready_d;
  logic [PW-1:0]     acc_step;
  logic [PW-1:0]     final_val;
  logic [WIDTH-1:0]  a_in, b_in;

`ifdef SEQ_MUL_SIGNED_EN
  logic sign_q, sign_d;

  // Magnitudes fit in WIDTH bits even for the most negative value (2^(WIDTH-1))
  always_comb begin
    a_in   = multiplicand[WIDTH-1] ? -multiplicand : multiplicand;
    b_in   = multiplier[WIDTH-1]   ? -multiplier   : multiplier;
    sign_d = sign_q;
    if (state_q != ARITH_BUSY && start) begin
      sign_d = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
    end
    final_val = sign_q ? -acc_step : acc_step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
    end
  end
`else
  always_comb begin
    a_in      = multiplicand;
    b_in      = multiplier;
    final_val = acc_step;
  end
`endif

  always_comb begin
    acc_step  = b_q[0] ? (acc_q + a_q) : acc_q;
    state_d   = state_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ready_d   = ready_q;
    unique case (state_q)
      ARITH_BUSY: begin
        acc_d = acc_step;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          product_d = final_val;
          state_d   = ARITH_DONE;
          ready_d   = 1'b1;
        end
      end
      default: begin
        if (start) begin
          a_d     = {{WIDTH{1'b0}}, a_in};
          b_d     = b_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ARITH_BUSY;
          ready_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARITH_IDLE;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ready_q   <= ready_d;
    end
  end

  assign product = product_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_seq_multiplier_8bit.sv
// tb/tb_seq_multiplier_8bit.sv - directed scoreboard bench for seq_multiplier_8bit
module tb_seq_multiplier_8bit;
  import coal_arith_pkg::*;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [2*W-1:0] product;
  logic           ready;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_result;

  seq_multiplier_8bit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MUL_SIGNED_EN
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
`else
    logic [2*W-1:0] ua, ub;
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    return ua * ub;
`endif
  endfunction

  // Accept at the next edge, then count cycles of ready=0; inject>0 pulses a stray start on that busy cycle
  task automatic do_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] expv, input int inject);
    int lowcnt;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    lowcnt = 0;
    while (!ready && lowcnt < 40) begin
      lowcnt++;
      if (lowcnt == inject) begin
        start        = 1'b1;
        multiplicand = 8'd9;
        multiplier   = 8'd9;
      end else begin
        start = 1'b0;
      end
      if (lowcnt == 2) chk({tag, "_busy_hold"}, 32'(product), 32'(last_result));
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_latency"}, lowcnt, W);
    if (exp_q.size() > 0) begin
      last_result = exp_q.pop_front();
      chk({tag, "_product"}, 32'(product), 32'(last_result));
    end else begin
      chk({tag, "_scoreboard_empty"}, 0, 1);
    end
    chk({tag, "_ready"}, 32'(ready), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    last_result = '0;
    #12;
    chk("reset_product", 32'(product), 0);
    chk("reset_ready", 32'(ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    do_mul("m100x7", 8'd100, 8'd7, ref_mul(8'd100, 8'd7), 0);
    chk("m100x7_const", 32'(last_result), 32'd700);
    repeat (3) @(negedge clk);
    chk("m100x7_hold", 32'(product), 32'd700);

    do_mul("m255x255", 8'd255, 8'd255, ref_mul(8'd255, 8'd255), 0);
    do_mul("m0x37", 8'd0, 8'd37, 16'd0, 0);
    do_mul("m37x0", 8'd37, 8'd0, 16'd0, 0);
    do_mul("inflight", 8'd55, 8'd5, 16'd275, 3);
    do_mul("m13x19", 8'd13, 8'd19, ref_mul(8'd13, 8'd19), 0);

    // Reset partway through a multiply must clear outputs without a clock edge
    @(negedge clk);
    multiplicand = 8'd200;
    multiplier   = 8'd3;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_busy", 32'(ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_product", 32'(product), 0);
    chk("midreset_ready", 32'(ready), 1);
    last_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_mul("m12x12", 8'd12, 8'd12, 16'd144, 0);

`ifdef SEQ_MUL_SIGNED_EN
    do_mul("s_m128xm128", 8'h80, 8'h80, 16'h4000, 0);
    do_mul("s_m128x1", 8'h80, 8'h01, 16'hFF80, 0);
    do_mul("s_m7x6", 8'hF9, 8'h06, 16'hFFD6, 0);
`endif

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
